gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 Parameter BINARY, default 0: 0 selects the subtract/swap Euclid algorithm; 1 selects binary (Stein) GCD.
REQ-003 Parameter CW, default 16: width of the cycle-count output.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair a/b is presented.
REQ-007 in_ready  output  1  engine can accept an operand pair.
REQ-008 a  input  WIDTH  first operand, unsigned.
REQ-009 b  input  WIDTH  second operand, unsigned.
REQ-010 out_valid  output  1  gcd and cycles are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 gcd  output  WIDTH  result, unsigned.
REQ-013 cycles  output  CW  number of CALC cycles used for this result.
REQ-014 busy  output  1  high while in CALC.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 The FSM SHALL encode outputs as follows: in_ready=1 only in IDLE; busy=1 only in CALC; out_valid=1 only in DONE.
REQ-017 When in IDLE with in_valid=1 on a clock edge, the engine SHALL load xr=a, yr=b, k=0 and cnt=0, and SHALL enter CALC.
REQ-018 When in IDLE with in_valid=0, the engine SHALL remain in IDLE and SHALL leave gcd and cycles unchanged.
REQ-019 Each CALC cycle SHALL perform exactly one step and SHALL increment cnt, saturating at 2^CW-1 with no wrap.
REQ-020 The Euclid step (BINARY=0), in priority order: if yr==0, then gcd<=xr, cycles<=cnt+1 (saturating) and enter DONE; else if xr<yr, swap xr and yr; else xr<=xr-yr.
REQ-021 The binary step (BINARY=1), in priority order:
- if xr==0 or yr==0: gcd<=(xr|yr)<<k, cycles<=cnt+1, enter DONE;
- else if both even: shift both right by 1 and do k+1;
- else if xr even: xr>>1;
- else if yr even: yr>>1;
- else if xr>=yr: xr<=xr-yr;
- else: yr<=yr-xr.
REQ-022 All subtractions SHALL be WIDTH-bit and never underflow, because of the ordering in REQ-020 and REQ-021.
REQ-023 k SHALL be wide enough to hold WIDTH; the shifted result SHALL fit in WIDTH bits.
REQ-024 Zero operands: gcd(0,0)=0, gcd(a,0)=a, gcd(0,b)=b in both modes.
REQ-025 In DONE, gcd and cycles SHALL hold stable while out_ready=0.
REQ-026 In DONE with out_ready=1, the result SHALL be consumed and the FSM SHALL return to IDLE on that edge; out_valid SHALL drop in the next cycle.
REQ-027 in_valid asserted outside IDLE SHALL be ignored; operands are sampled only at the accept edge.
REQ-028 Changes on a/b after acceptance SHALL NOT affect the computation in progress.
REQ-029 Latency from the accept edge to out_valid=1 SHALL equal the value reported on cycles (in clock cycles).

Reset
REQ-030 On reset=1 at a clock edge, regardless of state, the engine SHALL enter IDLE and SHALL set xr=yr=k=cnt=0, gcd=0, cycles=0, out_valid=0, busy=0 and in_ready=1.
REQ-031 Reset mid-CALC or in DONE SHALL discard the pending result; no out_valid SHALL follow.
REQ-032 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-033 Euclid, WIDTH=8: a=12, b=18 accepted, out_ready=1 -> out_valid after 7 cycles, gcd=6, cycles=7.
REQ-034 Binary, WIDTH=8: a=12, b=18 -> gcd=6, cycles=6; a=0, b=0 -> gcd=0, cycles=1.
REQ-035 Euclid, WIDTH=8: a=255, b=1 -> gcd=1, cycles=257; with CW=8 -> cycles=255 (saturated).
REQ-036 Backpressure: a=0, b=9, out_ready held 0 for 10 cycles -> out_valid stays 1, gcd=9 stable, in_ready=0, and a second in_valid is ignored; raising out_ready returns the FSM to IDLE.
REQ-037 Reset is asserted 3 cycles into CALC for a=200, b=3 -> the next cycle shows IDLE with gcd=0, cycles=0 and in_ready=1; then a=21, b=14 -> gcd=7.
REQ-038 Random: for WIDTH=16 in both modes, 10k random pairs, including zeros and equal pairs, are compared against a reference model -> all gcd values match, and each latency equals cycles.

Source files
------------

// File: rtl/gcd_engine.sv
// Iterative GCD engine with a valid/ready handshake on both sides.
// It computes with either subtract/swap Euclid or binary (Stein) GCD, and it reports how many compute cycles each result took.
module gcd_engine #(
    parameter int WIDTH  = 8,
    parameter int BINARY = 0,
    parameter int CW     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic [CW-1:0]    cycles,
    output logic             busy
);

    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   xr_r, xr_s, yr_r, yr_s;
    logic [KW-1:0]      k_r, k_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [WIDTH-1:0]   gcd_r, gcd_s;
    logic [CW-1:0]      cycles_r, cycles_s;
    logic               in_ready_r, in_ready_s;
    logic               busy_r, busy_s;
    logic               out_valid_r, out_valid_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Next-state and datapath step logic.
    always_comb begin
        state_s  = state_r;
        xr_s     = xr_r;
        yr_s     = yr_r;
        k_s      = k_r;
        cnt_s    = cnt_r;
        gcd_s    = gcd_r;
        cycles_s = cycles_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    xr_s    = a;
                    yr_s    = b;
                    k_s     = {KW{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                cnt_s = sat_inc(cnt_r);
                if (BINARY == 0) begin
                    if (yr_r == {WIDTH{1'b0}}) begin
                        gcd_s    = xr_r;
                        cycles_s = sat_inc(cnt_r);
                        state_s  = DONE;
                    end else if (xr_r < yr_r) begin
                        xr_s = yr_r;
                        yr_s = xr_r;
                    end else begin
                        xr_s = xr_r - yr_r;
                    end
                end else begin
                    // Common factors of two are tracked in k and restored on completion.
                    if ((xr_r == {WIDTH{1'b0}}) || (yr_r == {WIDTH{1'b0}})) begin
                        gcd_s    = (xr_r | yr_r) << k_r;
                        cycles_s = sat_inc(cnt_r);
                        state_s  = DONE;
                    end else if (!xr_r[0] && !yr_r[0]) begin
                        xr_s = xr_r >> 1;
                        yr_s = yr_r >> 1;
                        k_s  = k_r + KW'(1);
                    end else if (!xr_r[0]) begin
                        xr_s = xr_r >> 1;
                    end else if (!yr_r[0]) begin
                        yr_s = yr_r >> 1;
                    end else if (xr_r >= yr_r) begin
                        xr_s = xr_r - yr_r;
                    end else begin
                        yr_s = yr_r - xr_r;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        in_ready_s  = (state_s == IDLE);
        busy_s      = (state_s == CALC);
        out_valid_s = (state_s == DONE);
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            xr_r        <= {WIDTH{1'b0}};
            yr_r        <= {WIDTH{1'b0}};
            k_r         <= {KW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            gcd_r       <= {WIDTH{1'b0}};
            cycles_r    <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            xr_r        <= xr_s;
            yr_r        <= yr_s;
            k_r         <= k_s;
            cnt_r       <= cnt_s;
            gcd_r       <= gcd_s;
            cycles_r    <= cycles_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign gcd       = gcd_r;
    assign cycles    = cycles_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: Euclid/binary at WIDTH=8, a saturating CW=8 Euclid, and WIDTH=16 random pairs.
module tb_gcd_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        iv;
    logic        out_ready_v;
    logic [15:0] a_v, b_v;
    int          sel;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    logic iv0, iv1, iv2, iv3, iv4;
    logic ir0, ir1, ir2, ir3, ir4;
    logic ov0, ov1, ov2, ov3, ov4;
    logic bz0, bz1, bz2, bz3, bz4;
    logic [7:0]  g0, g1, g2;
    logic [15:0] g3, g4;
    logic [15:0] c0, c1, c3, c4;
    logic [7:0]  c2;

    assign iv0 = iv && (sel == 0);
    assign iv1 = iv && (sel == 1);
    assign iv2 = iv && (sel == 2);
    assign iv3 = iv && (sel == 3);
    assign iv4 = iv && (sel == 4);

    gcd_engine #(.WIDTH(8), .BINARY(0), .CW(16)) u_e8 (
        .clock(clock), .reset(reset), .in_valid(iv0), .in_ready(ir0), .a(a_v[7:0]), .b(b_v[7:0]),
        .out_valid(ov0), .out_ready(out_ready_v), .gcd(g0), .cycles(c0), .busy(bz0));
    gcd_engine #(.WIDTH(8), .BINARY(1), .CW(16)) u_b8 (
        .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a_v[7:0]), .b(b_v[7:0]),
        .out_valid(ov1), .out_ready(out_ready_v), .gcd(g1), .cycles(c1), .busy(bz1));
    gcd_engine #(.WIDTH(8), .BINARY(0), .CW(8)) u_s8 (
        .clock(clock), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a_v[7:0]), .b(b_v[7:0]),
        .out_valid(ov2), .out_ready(out_ready_v), .gcd(g2), .cycles(c2), .busy(bz2));
    gcd_engine #(.WIDTH(16), .BINARY(1), .CW(16)) u_b16 (
        .clock(clock), .reset(reset), .in_valid(iv3), .in_ready(ir3), .a(a_v), .b(b_v),
        .out_valid(ov3), .out_ready(out_ready_v), .gcd(g3), .cycles(c3), .busy(bz3));
    gcd_engine #(.WIDTH(16), .BINARY(0), .CW(16)) u_e16 (
        .clock(clock), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a_v), .b(b_v),
        .out_valid(ov4), .out_ready(out_ready_v), .gcd(g4), .cycles(c4), .busy(bz4));

    logic        ov_s, ir_s, bz_s;
    logic [15:0] g_s, c_s;

    always_comb begin
        ov_s = 1'b0; ir_s = 1'b0; bz_s = 1'b0; g_s = 16'd0; c_s = 16'd0;
        case (sel)
            0: begin ov_s = ov0; ir_s = ir0; bz_s = bz0; g_s = {8'd0, g0}; c_s = c0; end
            1: begin ov_s = ov1; ir_s = ir1; bz_s = bz1; g_s = {8'd0, g1}; c_s = c1; end
            2: begin ov_s = ov2; ir_s = ir2; bz_s = bz2; g_s = {8'd0, g2}; c_s = {8'd0, c2}; end
            3: begin ov_s = ov3; ir_s = ir3; bz_s = bz3; g_s = g3; c_s = c3; end
            4: begin ov_s = ov4; ir_s = ir4; bz_s = bz4; g_s = g4; c_s = c4; end
            default: begin ov_s = 1'b0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one operand pair for the accept edge, then scramble the operands.
    task automatic start(input int s, input logic [15:0] x, input logic [15:0] y);
        sel = s; a_v = x; b_v = y; iv = 1'b1;
        tick();
        iv = 1'b0; a_v = ~x; b_v = ~y;
    endtask

    task automatic wait_out(input int limit, output int lat);
        lat = 0;
        while (ov_s !== 1'b1 && lat < limit) begin
            tick();
            lat++;
        end
        if (ov_s !== 1'b1) chk("timeout_out_valid", {31'd0, ov_s}, 32'd1);
    endtask

    task automatic run(input int s, input logic [15:0] x, input logic [15:0] y, input int limit,
                       output int lat, output logic [15:0] gg, output logic [15:0] cc);
        start(s, x, y);
        wait_out(limit, lat);
        gg = g_s;
        cc = c_s;
        if (out_ready_v) tick();
    endtask

    initial begin
        int lat;
        logic [15:0] gg, cc;
        logic [15:0] x, y;
        logic seen;

        reset = 1'b1; iv = 1'b0; out_ready_v = 1'b1; a_v = 16'd0; b_v = 16'd0; sel = 0;
        repeat (2) tick();
        chk("rst_in_ready", {31'd0, ir_s}, 32'd1);
        chk("rst_out_valid", {31'd0, ov_s}, 32'd0);
        chk("rst_busy", {31'd0, bz_s}, 32'd0);
        chk("rst_gcd", {16'd0, g_s}, 32'd0);
        chk("rst_cycles", {16'd0, c_s}, 32'd0);
        reset = 1'b0;
        tick();

        // Euclid 12,18
        start(0, 16'd12, 16'd18);
        chk("e8_busy", {31'd0, bz_s}, 32'd1);
        chk("e8_not_ready", {31'd0, ir_s}, 32'd0);
        wait_out(2000, lat);
        chk("e8_12_18_lat", lat, 32'd7);
        chk("e8_12_18_gcd", {16'd0, g_s}, 32'd6);
        chk("e8_12_18_cycles", {16'd0, c_s}, 32'd7);
        tick();
        chk("e8_consume_ov", {31'd0, ov_s}, 32'd0);
        chk("e8_consume_ir", {31'd0, ir_s}, 32'd1);
        repeat (3) tick();
        chk("idle_hold_gcd", {16'd0, g_s}, 32'd6);
        chk("idle_hold_cycles", {16'd0, c_s}, 32'd7);

        // Binary mode
        run(1, 16'd12, 16'd18, 2000, lat, gg, cc);
        chk("b8_12_18_gcd", {16'd0, gg}, 32'd6);
        chk("b8_12_18_cycles", {16'd0, cc}, 32'd6);
        chk("b8_12_18_lat", lat, 32'd6);
        run(1, 16'd0, 16'd0, 2000, lat, gg, cc);
        chk("b8_0_0_gcd", {16'd0, gg}, 32'd0);
        chk("b8_0_0_cycles", {16'd0, cc}, 32'd1);
        run(1, 16'd0, 16'd5, 2000, lat, gg, cc);
        chk("b8_0_5_gcd", {16'd0, gg}, 32'd5);
        run(1, 16'd7, 16'd0, 2000, lat, gg, cc);
        chk("b8_7_0_gcd", {16'd0, gg}, 32'd7);
        run(0, 16'd0, 16'd0, 2000, lat, gg, cc);
        chk("e8_0_0_gcd", {16'd0, gg}, 32'd0);
        chk("e8_0_0_cycles", {16'd0, cc}, 32'd1);

        // Long Euclid run, with and without counter saturation
        run(0, 16'd255, 16'd1, 2000, lat, gg, cc);
        chk("e8_255_1_gcd", {16'd0, gg}, 32'd1);
        chk("e8_255_1_cycles", {16'd0, cc}, 32'd257);
        chk("e8_255_1_lat", lat, 32'd257);
        run(2, 16'd255, 16'd1, 2000, lat, gg, cc);
        chk("s8_255_1_gcd", {16'd0, gg}, 32'd1);
        chk("s8_255_1_cycles_sat", {16'd0, cc}, 32'd255);

        // Backpressure with an ignored second request
        out_ready_v = 1'b0;
        start(0, 16'd0, 16'd9);
        wait_out(2000, lat);
        chk("bp_gcd", {16'd0, g_s}, 32'd9);
        chk("bp_cycles", {16'd0, c_s}, 32'd2);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                iv = 1'b1; a_v = 16'd1; b_v = 16'd1;
            end else begin
                iv = 1'b0;
            end
            tick();
            chk("bp_hold_ov", {31'd0, ov_s}, 32'd1);
            chk("bp_hold_gcd", {16'd0, g_s}, 32'd9);
            chk("bp_hold_ir", {31'd0, ir_s}, 32'd0);
        end
        iv = 1'b0;
        chk("bp_hold_cycles", {16'd0, c_s}, 32'd2);
        out_ready_v = 1'b1;
        tick();
        chk("bp_release_ov", {31'd0, ov_s}, 32'd0);
        chk("bp_release_ir", {31'd0, ir_s}, 32'd1);
        chk("bp_release_gcd", {16'd0, g_s}, 32'd9);
        tick();
        chk("bp_no_second_calc", {31'd0, bz_s}, 32'd0);

        // Reset three cycles into CALC
        start(0, 16'd200, 16'd3);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ir", {31'd0, ir_s}, 32'd1);
        chk("midrst_gcd", {16'd0, g_s}, 32'd0);
        chk("midrst_cycles", {16'd0, c_s}, 32'd0);
        chk("midrst_busy", {31'd0, bz_s}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            seen = seen | ov_s;
        end
        chk("midrst_no_out_valid", {31'd0, seen}, 32'd0);
        run(0, 16'd21, 16'd14, 2000, lat, gg, cc);
        chk("e8_21_14_gcd", {16'd0, gg}, 32'd7);
        chk("e8_21_14_cycles", {16'd0, cc}, 32'd6);
        chk("e8_21_14_lat", lat, 32'd6);

        // Reset while holding a result in DONE
        out_ready_v = 1'b0;
        start(1, 16'd8, 16'd12);
        wait_out(2000, lat);
        chk("b8_8_12_gcd", {16'd0, g_s}, 32'd4);
        chk("b8_8_12_cycles", {16'd0, c_s}, 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready_v = 1'b1;
        chk("donerst_ov", {31'd0, ov_s}, 32'd0);
        chk("donerst_gcd", {16'd0, g_s}, 32'd0);
        tick();
        chk("donerst_ov_later", {31'd0, ov_s}, 32'd0);

        // Random WIDTH=16 pairs in both modes
        for (int m = 3; m <= 4; m++) begin
            for (int i = 0; i < 40; i++) begin
                x = 16'($urandom_range(65535, 512));
                y = 16'($urandom_range(65535, 512));
                if (m == 3 && i >= 8) begin
                    x = 16'($urandom_range(65535, 1));
                    y = 16'($urandom_range(65535, 1));
                end
                case (i)
                    0: begin x = 16'd0; y = 16'd0; end
                    1: begin x = 16'd0; end
                    2: begin y = 16'd0; end
                    3: begin y = x; end
                    default: begin end
                endcase
                run(m, x, y, 20000, lat, gg, cc);
                chk($sformatf("rand_gcd_m%0d_%0d_%0d", m, x, y), {16'd0, gg}, ref_gcd(int'(x), int'(y)));
                chk($sformatf("rand_lat_m%0d_%0d_%0d", m, x, y), lat, {16'd0, cc});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
